// File: rtl/accel_sched_pkg.sv
// accel_sched_pkg: shared state encodings, LED phase codes and defaults for the launch sequencer
package accel_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [1:0] PHASE_IDLE   = 2'b00;
    localparam logic [1:0] PHASE_LAUNCH = 2'b01;
    localparam logic [1:0] PHASE_WAIT   = 2'b10;
    localparam logic [1:0] PHASE_END    = 2'b11;

    localparam int DEFAULT_TIMEOUT = 1024;

    function automatic logic [1:0] phase_of(state_e s);
        return s == S_IDLE ? PHASE_IDLE : s == S_LAUNCH ? PHASE_LAUNCH : s == S_WAIT ? PHASE_WAIT : PHASE_END;
    endfunction

endpackage

// File: rtl/sched_timeout_ctr.sv
// sched_timeout_ctr: counts cycles while enabled and flags the last allowed cycle
module sched_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;

    // free count while enabled, synchronous clear takes priority
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign expired_o = en_i && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/core_launch_sequencer.sv
// core_launch_sequencer: staggered core start pulses, sticky done capture, timeout and LED phase
module core_launch_sequencer
    import accel_sched_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int CNT_W          = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NUM_CORES-1:0] core_mask_i,
    input  logic [NUM_CORES-1:0] core_done_i,
    output logic [NUM_CORES-1:0] core_start_o,
    output logic [NUM_CORES-1:0] done_mask_o,
    output logic                 busy_o,
    output logic                 all_done_o,
    output logic                 timeout_err_o,
    output logic [1:0]           phase_o
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_CORES - 1);

    state_e               state_q, state_d;
    logic [NUM_CORES-1:0] mask_q, mask_d, done_q, done_d, issued, start_q;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 accept, expired, all_done_q, err_q, busy_q;
    logic [1:0]           phase_q;

    assign accept = state_q == S_IDLE && start_i && |core_mask_i;
    assign mask_d = accept ? core_mask_i : mask_q;
    assign idx_d  = accept ? '0 : (state_q == S_LAUNCH ? idx_q + IW'(1) : idx_q);

    // a core's done counts only once its start pulse lies in the past
    always_comb begin
        issued = '0;
        for (int i = 0; i < NUM_CORES; i++)
            issued[i] = state_q == S_WAIT || (state_q == S_LAUNCH && IW'(i) < idx_q);
        done_d = done_q | (core_done_i & mask_q & issued);
    end

    // next state: abort beats completion, completion beats timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = accept ? S_LAUNCH : S_IDLE;
            S_LAUNCH: state_d = abort_i ? S_IDLE : (idx_q == LAST ? S_WAIT : S_LAUNCH);
            S_WAIT:   state_d = abort_i ? S_IDLE : done_d == mask_q ? S_DONE : expired ? S_ERROR : S_WAIT;
            default:  state_d = S_IDLE;
        endcase
    end

    // state, latched job context and all outputs registered from the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            idx_q      <= '0;
            done_q     <= '0;
            start_q    <= '0;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
            err_q      <= 1'b0;
            phase_q    <= PHASE_IDLE;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            done_q     <= accept ? '0 : done_d;
            start_q    <= state_d == S_LAUNCH ? mask_d & (NUM_CORES'(1) << idx_d) : '0;
            busy_q     <= state_d == S_LAUNCH || state_d == S_WAIT;
            all_done_q <= state_d == S_DONE;
            err_q      <= !accept && (err_q || state_d == S_ERROR);
            phase_q    <= phase_of(state_d);
        end
    end

    sched_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (state_q != S_WAIT),
        .en_i     (state_q == S_WAIT),
        .expired_o(expired)
    );

    assign core_start_o  = start_q;
    assign done_mask_o   = done_q;
    assign busy_o        = busy_q;
    assign all_done_o    = all_done_q;
    assign timeout_err_o = err_q;
    assign phase_o       = phase_q;

endmodule

// File: tb/tb_core_launch_sequencer.sv
// tb_core_launch_sequencer: directed checks of launch timing, done capture, timeout, abort and reset
module tb_core_launch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] mask = 4'h0;
    logic [3:0] done = 4'h0;
    logic [3:0] core_start, done_mask;
    logic       busy, all_done, timeout_err;
    logic [1:0] phase;
    int         total = 0;
    int         bad = 0;

    core_launch_sequencer #(
        .NUM_CORES     (4),
        .TIMEOUT_CYCLES(8),
        .CNT_W         (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .core_mask_i  (mask),
        .core_done_i  (done),
        .core_start_o (core_start),
        .done_mask_o  (done_mask),
        .busy_o       (busy),
        .all_done_o   (all_done),
        .timeout_err_o(timeout_err),
        .phase_o      (phase)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // packed {core_start, done_mask, busy, all_done, timeout_err, phase}
    task automatic expect_o(input string tag, input logic [3:0] cs, input logic [3:0] dm, input logic b,
                            input logic ad, input logic te, input logic [1:0] ph);
        logic [12:0] o, e;
        o = {core_start, done_mask, busy, all_done, timeout_err, phase};
        e = {cs, dm, b, ad, te, ph};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%b want=%b", tag, o, e);
        end
    endtask

    initial begin
        start = 1'b1; done = 4'hF; mask = 4'hF;
        step(); step();
        expect_o("reset", 4'h0, 4'h0, 0, 0, 0, 2'b00);
        start = 1'b0; done = 4'h0; rst_n = 1'b1;
        step();
        expect_o("idle", 4'h0, 4'h0, 0, 0, 0, 2'b00);

        mask = 4'hF; start = 1'b1;
        step(); start = 1'b0;
        expect_o("full_l0", 4'b0001, 4'h0, 1, 0, 0, 2'b01);
        step(); expect_o("full_l1", 4'b0010, 4'h0, 1, 0, 0, 2'b01);
        step(); expect_o("full_l2", 4'b0100, 4'h0, 1, 0, 0, 2'b01);
        step(); expect_o("full_l3", 4'b1000, 4'h0, 1, 0, 0, 2'b01);
        step(); expect_o("full_wait", 4'h0, 4'h0, 1, 0, 0, 2'b10);
        step(); step(); expect_o("full_wait3", 4'h0, 4'h0, 1, 0, 0, 2'b10);
        done = 4'hF;
        step(); expect_o("full_done", 4'h0, 4'hF, 0, 1, 0, 2'b11);
        done = 4'h0;
        step(); expect_o("full_idle", 4'h0, 4'hF, 0, 0, 0, 2'b00);

        mask = 4'b1010; start = 1'b1; done = 4'b0001;
        step(); start = 1'b0;
        expect_o("sparse_l0", 4'h0, 4'h0, 1, 0, 0, 2'b01);
        step(); expect_o("sparse_l1", 4'b0010, 4'h0, 1, 0, 0, 2'b01);
        step(); expect_o("sparse_l2", 4'h0, 4'h0, 1, 0, 0, 2'b01);
        done = 4'b0011;
        step(); expect_o("sparse_l3", 4'b1000, 4'b0010, 1, 0, 0, 2'b01);
        done = 4'b1011;
        step(); expect_o("sparse_wait", 4'h0, 4'b0010, 1, 0, 0, 2'b10);
        done = 4'b1000;
        step(); expect_o("sparse_done", 4'h0, 4'b1010, 0, 1, 0, 2'b11);
        done = 4'h0;
        step(); expect_o("sparse_idle", 4'h0, 4'b1010, 0, 0, 0, 2'b00);

        mask = 4'b0011; start = 1'b1; done = 4'b0001;
        step(); start = 1'b0;
        expect_o("to_l0", 4'b0001, 4'h0, 1, 0, 0, 2'b01);
        step(); expect_o("to_l1", 4'b0010, 4'h0, 1, 0, 0, 2'b01);
        step(); expect_o("to_l2", 4'h0, 4'b0001, 1, 0, 0, 2'b01);
        step(); expect_o("to_l3", 4'h0, 4'b0001, 1, 0, 0, 2'b01);
        step(); expect_o("to_wait1", 4'h0, 4'b0001, 1, 0, 0, 2'b10);
        for (int i = 0; i < 7; i++) begin
            step(); expect_o("to_waitn", 4'h0, 4'b0001, 1, 0, 0, 2'b10);
        end
        step(); expect_o("to_err", 4'h0, 4'b0001, 0, 0, 1, 2'b11);
        step(); expect_o("to_idle", 4'h0, 4'b0001, 0, 0, 1, 2'b00);

        start = 1'b1;
        step(); start = 1'b0;
        expect_o("race_l0", 4'b0001, 4'h0, 1, 0, 0, 2'b01);
        for (int i = 0; i < 11; i++) step();
        expect_o("race_w8", 4'h0, 4'b0001, 1, 0, 0, 2'b10);
        done = 4'b0011;
        step(); expect_o("race_done", 4'h0, 4'b0011, 0, 1, 0, 2'b11);
        done = 4'h0;
        step();

        mask = 4'hF; start = 1'b1;
        step(); start = 1'b0;
        expect_o("abort_l0", 4'b0001, 4'h0, 1, 0, 0, 2'b01);
        step(); expect_o("abort_l1", 4'b0010, 4'h0, 1, 0, 0, 2'b01);
        abort = 1'b1;
        step(); abort = 1'b0;
        expect_o("abort", 4'h0, 4'h0, 0, 0, 0, 2'b00);
        step(); step(); expect_o("abort_quiet", 4'h0, 4'h0, 0, 0, 0, 2'b00);

        mask = 4'b0001; start = 1'b1;
        step(); expect_o("busy_l0", 4'b0001, 4'h0, 1, 0, 0, 2'b01);
        mask = 4'hF;
        step(); expect_o("busy_start", 4'h0, 4'h0, 1, 0, 0, 2'b01);
        step(); step(); start = 1'b0;
        expect_o("busy_l3", 4'h0, 4'h0, 1, 0, 0, 2'b01);
        step(); done = 4'b0001;
        step(); expect_o("busy_done", 4'h0, 4'b0001, 0, 1, 0, 2'b11);
        done = 4'h0;
        step(); expect_o("busy_idle", 4'h0, 4'b0001, 0, 0, 0, 2'b00);

        mask = 4'h0; start = 1'b1;
        step(); start = 1'b0;
        expect_o("zero_mask", 4'h0, 4'b0001, 0, 0, 0, 2'b00);

        mask = 4'hF; start = 1'b1;
        step(); start = 1'b0;
        step(); expect_o("rst_l1", 4'b0010, 4'h0, 1, 0, 0, 2'b01);
        rst_n = 1'b0;
        #1 expect_o("async_rst", 4'h0, 4'h0, 0, 0, 0, 2'b00);
        step(); rst_n = 1'b1;
        step(); expect_o("rst_quiet", 4'h0, 4'h0, 0, 0, 0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
